// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and runtime baud divisor.
// Optional even-parity bit (DIV bit16 enable) is built when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd104
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_en_i,
  input  logic [1:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [15:0]   div_q;
  logic          par_en;
  logic [31:0]   rd_data_q;
  logic          irq_q;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          par_q, par_d;
  logic          tx;

  logic full, empty, pop, push, wr_data_hit;
  logic [15:0] cnt_load;
  logic [31:0] status;
  logic unused_ok;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign pop         = (state_q == S_IDLE) && !empty;
  assign wr_data_hit = wr_en_i && (wr_addr_i == 2'd0);
  // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
  assign push        = wr_data_hit && (!full || pop);
  assign cnt_load    = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign status      = {23'd0, 5'(count_q), ovf_q, empty, full, (state_q != S_IDLE)};
  assign unused_ok   = ^wr_data_i[31:16];

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  assign par_en = par_en_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              par_en_q <= 1'b0;
    else if (wr_en_i && wr_addr_i == 2'd2)    par_en_q <= wr_data_i[16];
  end
`else
  assign par_en = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_data_hit && !push)                  ovf_q <= 1'b1;
      else if (wr_en_i && wr_addr_i == 2'd1)     ovf_q <= 1'b0;
      if (wr_en_i && wr_addr_i == 2'd2)          div_q <= wr_data_i[15:0];
    end
  end

  // Reads sample state before any same-cycle write lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      irq_q     <= 1'b1;
    end else begin
      irq_q <= empty && (state_q == S_IDLE);
      if (rd_en_i) begin
        case (rd_addr_i)
          2'd1:    rd_data_q <= status;
          2'd2:    rd_data_q <= {15'd0, par_en, div_q};
          default: rd_data_q <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bitidx_q <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitidx_q <= bitidx_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitidx_d = bitidx_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    tx       = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d = mem_q[rptr_q];
          par_d   = ^mem_q[rptr_q];
          cnt_d   = cnt_load;
          state_d = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (cnt_q == 16'd0) begin
          cnt_d    = cnt_load;
          bitidx_d = 3'd0;
          state_d  = S_DATA;
        end else cnt_d = cnt_q - 16'd1;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (cnt_q == 16'd0) begin
          cnt_d   = cnt_load;
          shift_d = shift_q >> 1;
          if (bitidx_q == 3'd7) state_d = par_en ? S_PARITY : S_STOP;
          else                  bitidx_d = bitidx_q + 3'd1;
        end else cnt_d = cnt_q - 16'd1;
      end
      S_PARITY: begin
        tx = par_q;
        if (cnt_q == 16'd0) begin
          cnt_d   = cnt_load;
          state_d = S_STOP;
        end else cnt_d = cnt_q - 16'd1;
      end
      S_STOP: begin
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_o      = tx;
  assign irq_o     = irq_q;
  assign rd_data_o = rd_data_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register-access vector table plus hand-written frame sequences.
module tb_uart_tx_mmio;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [1:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx, irq;

  int total = 0;
  int bad   = 0;

  uart_tx_mmio #(.FIFO_DEPTH(4), .DIV_RESET(16'd104)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .tx_o(tx), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [1:0]  ra;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic we, logic [1:0] wa, logic [31:0] wd,
                              logic re, logic [1:0] ra, logic chk, logic [31:0] exp);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called on a falling edge; holds the strobes for exactly one rising edge.
  task automatic bus(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                     input logic re, input logic [1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Line receiver: samples each bit mid-cell at the bench's idea of the divisor.
  logic [7:0] rx_q [$];
  int         mon_div = 104;
  int         mon_gen = 0;
  bit         mon_en  = 1'b1;
  int         mg, md;
  logic [7:0] mb;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mon_en && tx === 1'b0) begin
        mg = mon_gen;
        md = (mon_div == 0) ? 1 : mon_div;
        repeat (md + md / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          mb[k] = tx;
          if (k < 7) repeat (md) @(negedge clk);
        end
        repeat (md) @(negedge clk);
        if (mg == mon_gen) rx_q.push_back(mb);
      end
    end
  end

  logic [9:0]  f10;
  logic [10:0] f11;
  logic [31:0] div_rb;
  bit          all_high;
  int          waited;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
`ifdef UART_TX_PARITY_EN
    div_rb = 32'h0001_0005;
`else
    div_rb = 32'h0000_0005;
`endif
    vecs[0]  = mk(0, 2'd0, 32'h0,         1, 2'd1, 1, 32'h0000_0004);
    vecs[1]  = mk(0, 2'd0, 32'h0,         1, 2'd2, 1, 32'h0000_0068);
    vecs[2]  = mk(1, 2'd2, 32'h0000_1234, 0, 2'd0, 1, 32'h0000_0068);
    vecs[3]  = mk(0, 2'd0, 32'h0,         1, 2'd2, 1, 32'h0000_1234);
    vecs[4]  = mk(1, 2'd3, 32'hFFFF_FFFF, 1, 2'd3, 1, 32'h0000_0000);
    vecs[5]  = mk(0, 2'd0, 32'h0,         1, 2'd2, 1, 32'h0000_1234);
    vecs[6]  = mk(0, 2'd0, 32'h0,         1, 2'd0, 1, 32'h0000_0000);
    vecs[7]  = mk(1, 2'd2, 32'hABCD_0005, 0, 2'd0, 1, 32'h0000_0000);
    vecs[8]  = mk(0, 2'd0, 32'h0,         1, 2'd2, 1, div_rb);
    vecs[9]  = mk(1, 2'd1, 32'h0,         1, 2'd1, 1, 32'h0000_0004);
    vecs[10] = mk(1, 2'd2, 32'h0,         1, 2'd2, 1, div_rb);
    vecs[11] = mk(0, 2'd0, 32'h0,         1, 2'd2, 1, 32'h0000_0000);

    repeat (3) @(negedge clk);
    check("reset_tx",  {31'd0, tx},  32'd1);
    check("reset_irq", {31'd0, irq}, 32'd1);
    check("reset_rd",  rd_data,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      bus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      if (vecs[i].chk) check($sformatf("vec%0d", i), rd_data, vecs[i].exp);
    end

    // 0x55 at DIV=4: ten 4-cycle cells, then irq returns two cycles after STOP.
    bus(1, 2'd2, 32'd4, 0, 2'd0);
    mon_div = 4;
    bus(1, 2'd0, 32'h55, 0, 2'd0);
    @(negedge clk);
    f10 = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 42; i++) begin
      if (i < 40) check($sformatf("f55_tx%0d", i), {31'd0, tx}, {31'd0, f10[i / 4]});
      if (i == 0 || i == 40) check($sformatf("f55_irq%0d", i), {31'd0, irq}, 32'd0);
      if (i == 41) check("f55_irq_rise", {31'd0, irq}, 32'd1);
      @(negedge clk);
    end
    check("f55_rx_cnt", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("f55_rx_byte", {24'd0, rx_q[0]}, 32'h55);
    rx_q.delete();

    // Fill and overflow the FIFO behind a busy shifter at DIV=2.
    bus(1, 2'd2, 32'd2, 0, 2'd0);
    mon_div = 2;
    for (int k = 0; k < 6; k++) bus(1, 2'd0, 32'h41 + k, 0, 2'd0);
    bus(0, 2'd0, 32'h0, 1, 2'd1);
    check("ovf_status", rd_data, 32'h0000_004B);
    bus(1, 2'd1, 32'h0, 1, 2'd1);
    check("ovf_rd_prewrite", rd_data, 32'h0000_004B);
    bus(0, 2'd0, 32'h0, 1, 2'd1);
    check("ovf_cleared", rd_data, 32'h0000_0043);
    waited = 0;
    while (rx_q.size() < 5 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    repeat (40) @(negedge clk);
    check("ovf_rx_cnt", rx_q.size(), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < rx_q.size()) check($sformatf("ovf_rx%0d", k), {24'd0, rx_q[k]}, 32'h41 + k);
    check("ovf_irq_idle", {31'd0, irq}, 32'd1);
    bus(0, 2'd0, 32'h0, 1, 2'd1);
    check("ovf_status_idle", rd_data, 32'h0000_0004);
    rx_q.delete();

    // DIV=0 behaves as 1: one low cell then nine high cells.
    bus(1, 2'd2, 32'd0, 0, 2'd0);
    mon_div = 0;
    bus(1, 2'd0, 32'hFF, 0, 2'd0);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("div0_tx%0d", i), {31'd0, tx}, (i == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    check("div0_rx_cnt", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("div0_rx_byte", {24'd0, rx_q[0]}, 32'hFF);
    rx_q.delete();

    // Reset in the middle of byte 0xA3's data bits.
    bus(1, 2'd2, 32'd4, 0, 2'd0);
    mon_div = 4;
    bus(1, 2'd0, 32'hA3, 0, 2'd0);
    @(negedge clk);
    repeat (14) @(negedge clk);
    check("rst_mid_tx", {31'd0, tx}, 32'd0);
    bus(0, 2'd0, 32'h0, 1, 2'd1);
    check("rst_mid_status", rd_data, 32'h0000_0005);
    #2;
    rst_n = 1'b0;
    mon_gen++;
    #1;
    check("rst_async_tx",  {31'd0, tx},  32'd1);
    check("rst_async_irq", {31'd0, irq}, 32'd1);
    check("rst_async_rd",  rd_data,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus(0, 2'd0, 32'h0, 1, 2'd1);
    check("rst_status", rd_data, 32'h0000_0004);
    bus(0, 2'd0, 32'h0, 1, 2'd2);
    check("rst_div", rd_data, 32'h0000_0068);
    all_high = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1) all_high = 1'b0;
      @(negedge clk);
    end
    check("rst_no_residual", {31'd0, all_high}, 32'd1);
    check("rst_rx_cnt", rx_q.size(), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 11 cells of 3 cycles, even parity before stop.
    mon_en = 1'b0;
    bus(1, 2'd2, 32'h0001_0003, 0, 2'd0);
    bus(1, 2'd0, 32'h07, 0, 2'd0);
    @(negedge clk);
    f11 = {1'b1, 1'b1, 8'h07, 1'b0};
    for (int i = 0; i < 34; i++) begin
      if (i < 33) check($sformatf("par07_tx%0d", i), {31'd0, tx}, {31'd0, f11[i / 3]});
      @(negedge clk);
    end
    bus(1, 2'd0, 32'h03, 0, 2'd0);
    @(negedge clk);
    f11 = {1'b1, 1'b0, 8'h03, 1'b0};
    for (int i = 0; i < 34; i++) begin
      if (i < 33) check($sformatf("par03_tx%0d", i), {31'd0, tx}, {31'd0, f11[i / 3]});
      @(negedge clk);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
